// File: rtl/fetch_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_pipe_ctrl
//
// Fetch-side consumer of the hazard-unit control interface. It owns the PC
// register and the IF/ID pipeline latch. Each cycle it applies PCWrite,
// IFIDWrite, BranchFlush and ControlStall, and it takes redirects that are
// resolved in ID. When the halt word is fetched, the block drains the pipe
// with bubbles and then reports Halted. It also keeps saturating stall and
// flush counters for the debug unit.
//
// Ports
//   Clk           in   1       rising-edge clock
//   Rst_n         in   1       asynchronous active-low reset
//   Enable        in   1       run/step enable; 0 freezes every register
//   Start         in   1       leave IDLE and begin fetching
//   PCWrite       in   1       hazard unit: PC may update
//   IFIDWrite     in   1       hazard unit: IF/ID loads the fetched word
//   BranchFlush   in   1       hazard unit: squash the wrong-path fetch
//   ControlStall  in   1       hazard unit: bubble into ID/EX
//   Redirect      in   1       taken branch / jump resolved in ID
//   RedirectPC    in   DATA_W  redirect target
//   Instr_IM      in   DATA_W  instruction memory read data (addressed by PC_IM)
//   PC_IM         out  DATA_W  current PC / instruction memory address
//   Instr_IFID    out  DATA_W  IF/ID instruction
//   PCPlus4_IFID  out  DATA_W  IF/ID PC+4
//   Valid_IFID    out  1       IF/ID holds a real instruction
//   Bubble_IDEX   out  1       registered ControlStall
//   Halted        out  1       pipe drained after the halt word
//   StallCount    out  CNT_W   enabled RUN cycles with PCWrite=0 (saturating)
//   FlushCount    out  CNT_W   IF/ID flushes inserted (saturating)
// ---------------------------------------------------------------------------
module fetch_pipe_ctrl #(
    parameter int unsigned       DATA_W       = 32,
    parameter logic [DATA_W-1:0] RESET_PC     = '0,
    parameter logic [DATA_W-1:0] HALT_WORD    = '1,
    parameter logic [DATA_W-1:0] NOP_WORD     = '0,
    parameter int unsigned       DRAIN_CYCLES = 4,
    parameter int unsigned       CNT_W        = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Enable,
    input  logic              Start,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              BranchFlush,
    input  logic              ControlStall,
    input  logic              Redirect,
    input  logic [DATA_W-1:0] RedirectPC,
    input  logic [DATA_W-1:0] Instr_IM,
    output logic [DATA_W-1:0] PC_IM,
    output logic [DATA_W-1:0] Instr_IFID,
    output logic [DATA_W-1:0] PCPlus4_IFID,
    output logic              Valid_IFID,
    output logic              Bubble_IDEX,
    output logic              Halted,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    // The drain counter must be at least one bit wide, even when DRAIN_CYCLES=1.
    localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] pc_q,     pc_d;
    logic [DATA_W-1:0] instr_q,  instr_d;
    logic [DATA_W-1:0] pcp4_q,   pcp4_d;
    logic              valid_q,  valid_d;
    logic              bubble_q, bubble_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;

    logic [DATA_W-1:0] pc_plus4;
    logic              halt_detect;

    assign pc_plus4 = pc_q + DATA_W'(4);

    // The halt sequence starts only when the halt word would actually be
    // accepted into IF/ID; a stalled fetch of it is not a halt yet.
    assign halt_detect = (state_q == ST_RUN) && IFIDWrite && (Instr_IM == HALT_WORD);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the order
    // in which the processes are evaluated.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic. With Enable low, nothing advances.
    // -----------------------------------------------------------------------
    // NOTE: each combinational output gets a default at the top of the block,
    // so that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (Enable) begin
            unique case (state_q)
                ST_IDLE:   if (Start)              state_d = ST_RUN;
                ST_RUN:    if (halt_detect)        state_d = ST_DRAIN;
                ST_DRAIN:  if (drain_cnt_q == '0)  state_d = ST_HALTED;
                ST_HALTED:                         state_d = ST_HALTED;
                default:                           state_d = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM output / datapath control: next values for the PC, the IF/ID latch,
    // the bubble flag and the counters.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        bubble_d    = bubble_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        drain_cnt_d = drain_cnt_q;

        if (Enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Outputs keep their reset values until Start.
                end

                ST_RUN: begin
                    bubble_d = ControlStall;

                    if (!PCWrite && (stall_cnt_q != '1)) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end

                    if (halt_detect) begin
                        // The halt word never enters IF/ID, and the PC stays
                        // on the halt address for the debugger.
                        instr_d     = NOP_WORD;
                        valid_d     = 1'b0;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        if (IFIDWrite) begin
                            instr_d = Instr_IM;
                            pcp4_d  = pc_plus4;
                            valid_d = 1'b1;
                        end else if (BranchFlush && PCWrite) begin
                            // A flush counts only when the PC really moves
                            // off the wrong path. A stall holds the latch.
                            instr_d = NOP_WORD;
                            valid_d = 1'b0;
                            if (flush_cnt_q != '1) begin
                                flush_cnt_d = flush_cnt_q + CNT_W'(1);
                            end
                        end

                        // A stall takes priority over a redirect, and the
                        // redirect is presented again next cycle.
                        if (PCWrite) begin
                            pc_d = Redirect ? RedirectPC : pc_plus4;
                        end
                    end
                end

                ST_DRAIN: begin
                    instr_d  = NOP_WORD;
                    valid_d  = 1'b0;
                    bubble_d = ControlStall;
                    if (drain_cnt_q != '0) begin
                        drain_cnt_d = drain_cnt_q - DRN_W'(1);
                    end
                end

                ST_HALTED: begin
                    instr_d  = NOP_WORD;
                    valid_d  = 1'b0;
                    bubble_d = 1'b0;
                end

                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_WORD;
            pcp4_q      <= '0;
            valid_q     <= 1'b0;
            bubble_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            bubble_q    <= bubble_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign PC_IM        = pc_q;
    assign Instr_IFID   = instr_q;
    assign PCPlus4_IFID = pcp4_q;
    assign Valid_IFID   = valid_q;
    assign Bubble_IDEX  = bubble_q;
    assign Halted       = (state_q == ST_HALTED);
    assign StallCount   = stall_cnt_q;
    assign FlushCount   = flush_cnt_q;

endmodule
